// File: rtl/scarv_cop_sgmem.sv
// scarv_cop_sgmem
// Scatter/gather memory engine for the SCARV coprocessor. Moves up to
// DATA_W/8 byte, halfword or word elements between one packed CPR value and
// independently addressed memory words, one bus transaction per element.
// Gathered data is written back only when every element completed cleanly.
// Optional strided addressing is compiled in when SCARV_COP_SG_STRIDE_EN is
// defined; otherwise sg_mode and sg_stride are ignored.
module scarv_cop_sgmem #(
    parameter int DATA_W = 32
) (
    input  logic                          g_clk,
    input  logic                          g_resetn,
    input  logic                          sg_ivalid,
    output logic                          sg_idone,
    input  logic                          sg_is_store,
    input  logic [1:0]                    sg_esize,
    input  logic                          sg_mode,
    input  logic [$clog2(DATA_W/8):0]     sg_nelem,
    input  logic [31:0]                   sg_base,
    input  logic [31:0]                   sg_stride,
    input  logic [DATA_W-1:0]             sg_index,
    input  logic [DATA_W-1:0]             sg_sdata,
    output logic [DATA_W-1:0]             sg_rd_wdata,
    output logic [DATA_W/8-1:0]           sg_rd_ben,
    output logic                          sg_addr_error,
    output logic                          sg_bus_error,
    output logic                          cop_mem_cen,
    output logic                          cop_mem_wen,
    output logic [31:0]                   cop_mem_addr,
    output logic [31:0]                   cop_mem_wdata,
    output logic [3:0]                    cop_mem_ben,
    input  logic [31:0]                   cop_mem_rdata,
    input  logic                          cop_mem_stall,
    input  logic                          cop_mem_error
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned NW = $clog2(DATA_W / 8) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [NW-1:0]     cnt_q, cnt_n;
    logic [DATA_W-1:0] buf_q, buf_n;
    logic              aerr_q, aerr_n;
    logic              berr_q, berr_n;
    logic [1:0]        off_q;

    logic [31:0]       esz_b;
    logic [NW-1:0]     cap;
    logic [NW-1:0]     n_eff;
    logic [NW-1:0]     e_sel;
    logic [31:0]       e_addr;
    logic              aerr_c;
    logic              accept;
    logic              last;
    logic              bus_load;
    logic              bus_drop;
    logic [31:0]       bus_wdata_n;
    logic [3:0]        bus_ben_n;
    logic              done_set;
    logic [DATA_W-1:0] wb_wdata_n;
    logic [NB-1:0]     wb_ben_n;

`ifdef SCARV_COP_SG_STRIDE_EN
    logic              mode_q;
`else
    logic              unused_stride;
    assign unused_stride = ^{sg_mode, sg_stride};
`endif

    // Element size in bytes and effective element count (0 or >CAP means CAP).
    always_comb begin
        esz_b = 32'd1 << sg_esize;
        cap   = NW'(NB >> sg_esize);
        n_eff = ((sg_nelem == '0) || (sg_nelem > cap)) ? cap : sg_nelem;
    end

    // Alignment pre-check of every active element; only address bits [1:0] matter.
    always_comb begin
        logic [1:0]  lo;
        int unsigned bi;
`ifdef SCARV_COP_SG_STRIDE_EN
        logic [31:0] prod;
`endif
        aerr_c = (sg_esize == 2'b11);
        for (int unsigned i = 0; i < NB; i++) begin
            lo = 2'b00;
            bi = i << sg_esize;
            if (bi < NB) begin
                lo = sg_base[1:0] + sg_index[8*bi +: 2];
            end
`ifdef SCARV_COP_SG_STRIDE_EN
            if (mode_q) begin
                prod = i * sg_stride;
                lo   = sg_base[1:0] + prod[1:0];
            end
`endif
            if ((i < 32'(n_eff)) &&
                (((sg_esize == 2'b01) && lo[0]) ||
                 ((sg_esize == 2'b10) && (lo != 2'b00)))) begin
                aerr_c = 1'b1;
            end
        end
    end

    // Byte address of the element selected for the next bus request.
    always_comb begin
        int unsigned e_int;
        int unsigned bi;
        logic [31:0] idx_off;
        e_int   = 32'(e_sel);
        idx_off = '0;
        bi      = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            bi = (e_int << sg_esize) + k;
            if ((k < esz_b) && (bi < NB)) begin
                idx_off[8*k +: 8] = sg_index[8*bi +: 8];
            end
        end
        e_addr = sg_base + idx_off;
`ifdef SCARV_COP_SG_STRIDE_EN
        if (mode_q) begin
            e_addr = sg_base + (e_int * sg_stride);
        end
`endif
    end

    // Store byte enables and lane-shifted write data for the selected element.
    always_comb begin
        int unsigned e_int;
        int unsigned off;
        int unsigned bi;
        e_int       = 32'(e_sel);
        off         = 32'(e_addr[1:0]);
        bi          = 0;
        bus_wdata_n = '0;
        bus_ben_n   = '0;
        if (sg_is_store) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if ((j >= off) && (j < off + esz_b)) begin
                    bus_ben_n[j] = 1'b1;
                    bi = (e_int << sg_esize) + (j - off);
                    if (bi < NB) begin
                        bus_wdata_n[8*j +: 8] = sg_sdata[8*bi +: 8];
                    end
                end
            end
        end
    end

    // Next-state, element counter and gather-buffer merge.
    always_comb begin
        int unsigned sb;
        state_n  = state_q;
        cnt_n    = cnt_q;
        buf_n    = buf_q;
        aerr_n   = aerr_q;
        berr_n   = berr_q;
        e_sel    = cnt_q;
        bus_load = 1'b0;
        bus_drop = 1'b0;
        sb       = 0;
        accept   = cop_mem_cen && !cop_mem_stall;
        last     = (cnt_q == (n_eff - NW'(1)));
        unique case (state_q)
            IDLE: begin
                if (sg_ivalid) begin
                    state_n = CHECK;
                    cnt_n   = '0;
                    buf_n   = '0;
                    aerr_n  = 1'b0;
                    berr_n  = 1'b0;
                end
            end
            CHECK: begin
                if (aerr_c) begin
                    aerr_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n  = ACCESS;
                    e_sel    = '0;
                    bus_load = 1'b1;
                end
            end
            ACCESS: begin
                if (accept) begin
                    if (cop_mem_error) begin
                        berr_n   = 1'b1;
                        state_n  = DONE;
                        bus_drop = 1'b1;
                    end else begin
                        if (!sg_is_store) begin
                            for (int unsigned b = 0; b < NB; b++) begin
                                if ((b >> sg_esize) == 32'(cnt_q)) begin
                                    sb = 32'(off_q) + (b & (esz_b - 32'd1));
                                    if (sb < 4) begin
                                        buf_n[8*b +: 8] = cop_mem_rdata[8*sb +: 8];
                                    end
                                end
                            end
                        end
                        if (last) begin
                            state_n  = DONE;
                            bus_drop = 1'b1;
                        end else begin
                            cnt_n    = cnt_q + NW'(1);
                            e_sel    = cnt_q + NW'(1);
                            bus_load = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Writeback values, captured on entry to DONE while the request is still held.
    always_comb begin
        done_set   = (state_q != DONE) && (state_n == DONE);
        wb_wdata_n = '0;
        wb_ben_n   = '0;
        if (!sg_is_store && !aerr_n && !berr_n) begin
            wb_wdata_n = buf_n;
            for (int unsigned b = 0; b < NB; b++) begin
                wb_ben_n[b] = ((b >> sg_esize) < 32'(n_eff));
            end
        end
    end

    // FSM state, element counter, gather buffer and error flags.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            buf_q   <= buf_n;
            aerr_q  <= aerr_n;
            berr_q  <= berr_n;
        end
    end

`ifdef SCARV_COP_SG_STRIDE_EN
    // Addressing mode is latched when the instruction is accepted.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mode_q <= 1'b0;
        end else if ((state_q == IDLE) && sg_ivalid) begin
            mode_q <= sg_mode;
        end
    end
`endif

    // Registered bus request; held unchanged while the bus stalls.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cop_mem_cen   <= 1'b0;
            cop_mem_wen   <= 1'b0;
            cop_mem_addr  <= '0;
            cop_mem_wdata <= '0;
            cop_mem_ben   <= '0;
            off_q         <= '0;
        end else if (bus_load) begin
            cop_mem_cen   <= 1'b1;
            cop_mem_wen   <= sg_is_store;
            cop_mem_addr  <= {e_addr[31:2], 2'b00};
            cop_mem_wdata <= bus_wdata_n;
            cop_mem_ben   <= bus_ben_n;
            off_q         <= e_addr[1:0];
        end else if (bus_drop) begin
            cop_mem_cen   <= 1'b0;
            cop_mem_wen   <= 1'b0;
            cop_mem_addr  <= '0;
            cop_mem_wdata <= '0;
            cop_mem_ben   <= '0;
            off_q         <= '0;
        end
    end

    // Completion pulse with writeback and error status, live only during DONE.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            sg_idone      <= 1'b0;
            sg_addr_error <= 1'b0;
            sg_bus_error  <= 1'b0;
            sg_rd_wdata   <= '0;
            sg_rd_ben     <= '0;
        end else if (done_set) begin
            sg_idone      <= 1'b1;
            sg_addr_error <= aerr_n;
            sg_bus_error  <= berr_n;
            sg_rd_wdata   <= wb_wdata_n;
            sg_rd_ben     <= wb_ben_n;
        end else begin
            sg_idone      <= 1'b0;
            sg_addr_error <= 1'b0;
            sg_bus_error  <= 1'b0;
            sg_rd_wdata   <= '0;
            sg_rd_ben     <= '0;
        end
    end

endmodule

// File: tb/tb_scarv_cop_sgmem.sv
// Scoreboard bench for scarv_cop_sgmem: directed instructions push their
// expected bus transactions and completion into queues; a monitor pops and
// compares whenever the DUT accepts a bus transaction or pulses sg_idone.
module tb_scarv_cop_sgmem;

`ifdef SCARV_COP_SG_STRIDE_EN
    localparam int DW = 64;
`else
    localparam int DW = 32;
`endif
    localparam int NB = DW / 8;
    localparam int NW = $clog2(NB) + 1;

    logic          g_clk;
    logic          g_resetn;
    logic          sg_ivalid;
    logic          sg_idone;
    logic          sg_is_store;
    logic [1:0]    sg_esize;
    logic          sg_mode;
    logic [NW-1:0] sg_nelem;
    logic [31:0]   sg_base;
    logic [31:0]   sg_stride;
    logic [DW-1:0] sg_index;
    logic [DW-1:0] sg_sdata;
    logic [DW-1:0] sg_rd_wdata;
    logic [NB-1:0] sg_rd_ben;
    logic          sg_addr_error;
    logic          sg_bus_error;
    logic          cop_mem_cen;
    logic          cop_mem_wen;
    logic [31:0]   cop_mem_addr;
    logic [31:0]   cop_mem_wdata;
    logic [3:0]    cop_mem_ben;
    logic [31:0]   cop_mem_rdata;
    logic          cop_mem_stall;
    logic          cop_mem_error;

    scarv_cop_sgmem #(.DATA_W(DW)) dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .sg_ivalid     (sg_ivalid),
        .sg_idone      (sg_idone),
        .sg_is_store   (sg_is_store),
        .sg_esize      (sg_esize),
        .sg_mode       (sg_mode),
        .sg_nelem      (sg_nelem),
        .sg_base       (sg_base),
        .sg_stride     (sg_stride),
        .sg_index      (sg_index),
        .sg_sdata      (sg_sdata),
        .sg_rd_wdata   (sg_rd_wdata),
        .sg_rd_ben     (sg_rd_ben),
        .sg_addr_error (sg_addr_error),
        .sg_bus_error  (sg_bus_error),
        .cop_mem_cen   (cop_mem_cen),
        .cop_mem_wen   (cop_mem_wen),
        .cop_mem_addr  (cop_mem_addr),
        .cop_mem_wdata (cop_mem_wdata),
        .cop_mem_ben   (cop_mem_ben),
        .cop_mem_rdata (cop_mem_rdata),
        .cop_mem_stall (cop_mem_stall),
        .cop_mem_error (cop_mem_error)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  ben;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int            lat;
        logic          aerr;
        logic          berr;
        logic [DW-1:0] wdata;
        logic [NB-1:0] ben;
    } done_t;

    txn_t  exp_txn[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;
    logic mon_en = 1'b1;

    // Bus responder configuration
    logic [31:0] rd_tab[8];
    int acc_idx    = 0;
    int stall_elem = -1;
    int stall_left = 0;
    int err_elem   = -1;

    logic        prev_stall = 1'b0;
    logic [69:0] prev_bus   = '0;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wen = w; t.ben = b; t.wdata = d;
        exp_txn.push_back(t);
    endtask

    task automatic push_done(input int lat, input logic ae, input logic be,
                             input logic [DW-1:0] wd, input logic [NB-1:0] bn);
        done_t d;
        d.lat = lat; d.aerr = ae; d.berr = be; d.wdata = wd; d.ben = bn;
        exp_done.push_back(d);
    endtask

    task automatic fill_rd(input logic [31:0] v);
        for (int i = 0; i < 8; i++) rd_tab[i] = v;
    endtask

    // Responder: drives stall, read data and error for the request on the bus.
    always @(posedge g_clk) begin
        #1;
        if (cop_mem_cen) begin
            cop_mem_stall = (acc_idx == stall_elem) && (stall_left > 0);
            if (cop_mem_stall) stall_left--;
            cop_mem_rdata = rd_tab[acc_idx % 8];
            cop_mem_error = !cop_mem_stall && (acc_idx == err_elem);
            if (!cop_mem_stall) acc_idx++;
        end else begin
            cop_mem_stall = 1'b0;
            cop_mem_error = 1'b0;
            cop_mem_rdata = '0;
        end
    end

    // Monitor: compares accepted transactions, stall holding and completions.
    always @(negedge g_clk) begin
        txn_t  t;
        done_t d;
        if (g_resetn && mon_en) begin
            if (prev_stall)
                chk("stall_hold", 128'({cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben}),
                    128'(prev_bus));
            if (cop_mem_cen && !cop_mem_stall) begin
                if (exp_txn.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL txn_unexpected: got addr %0h expected no transaction (cycle %0d)", cop_mem_addr, cyc);
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_addr",  128'(cop_mem_addr),  128'(t.addr));
                    chk("txn_wen",   128'(cop_mem_wen),   128'(t.wen));
                    chk("txn_ben",   128'(cop_mem_ben),   128'(t.ben));
                    chk("txn_wdata", 128'(cop_mem_wdata), 128'(t.wdata));
                end
            end
            prev_stall = cop_mem_cen && cop_mem_stall;
            prev_bus   = {cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben};
            if (sg_idone) begin
                if (exp_done.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL done_unexpected: got sg_idone expected none (cycle %0d)", cyc);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_latency",  128'(cyc - t0),        128'(d.lat));
                    chk("done_aerr",     128'(sg_addr_error),   128'(d.aerr));
                    chk("done_berr",     128'(sg_bus_error),    128'(d.berr));
                    chk("done_rd_wdata", 128'(sg_rd_wdata),     128'(d.wdata));
                    chk("done_rd_ben",   128'(sg_rd_ben),       128'(d.ben));
                    chk("txn_missing",   128'(exp_txn.size()),  128'(0));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Issue one instruction and hold it until sg_idone (bounded).
    task automatic run_op(input logic st, input logic [1:0] es, input logic md, input logic [NW-1:0] ne,
                          input logic [31:0] base, input logic [31:0] stride,
                          input logic [DW-1:0] idx, input logic [DW-1:0] sd);
        bit got;
        acc_idx = 0;
        @(posedge g_clk); #1;
        sg_is_store = st; sg_esize = es; sg_mode = md; sg_nelem = ne;
        sg_base = base; sg_stride = stride; sg_index = idx; sg_sdata = sd;
        sg_ivalid = 1'b1;
        t0 = cyc;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge g_clk);
            if (sg_idone) got = 1;
        end
        sg_ivalid = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no sg_idone expected one within 40 cycles");
            exp_txn.delete();
            exp_done.delete();
        end
        @(posedge g_clk); #1;
        stall_elem = -1; stall_left = 0; err_elem = -1;
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        bit seen;
        g_resetn = 1'b0; sg_ivalid = 1'b0; sg_is_store = 1'b0; sg_esize = 2'b00;
        sg_mode = 1'b0; sg_nelem = '0; sg_base = '0; sg_stride = '0;
        sg_index = '0; sg_sdata = '0;
        cop_mem_rdata = '0; cop_mem_stall = 1'b0; cop_mem_error = 1'b0;
        fill_rd(32'h0);

        repeat (3) @(negedge g_clk);
        chk("rst_idone",   128'(sg_idone),      128'(0));
        chk("rst_aerr",    128'(sg_addr_error), 128'(0));
        chk("rst_berr",    128'(sg_bus_error),  128'(0));
        chk("rst_rd_wdata",128'(sg_rd_wdata),   128'(0));
        chk("rst_rd_ben",  128'(sg_rd_ben),     128'(0));
        chk("rst_bus",     128'({cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben}), 128'(0));
        g_resetn = 1'b1;

`ifdef SCARV_COP_SG_STRIDE_EN
        // Strided word gather with negative stride
        rd_tab[0] = 32'h0000000A; rd_tab[1] = 32'h0000000B;
        push_txn(32'h100, 1'b0, 4'h0, 32'h0);
        push_txn(32'h0FC, 1'b0, 4'h0, 32'h0);
        push_done(4, 1'b0, 1'b0, DW'(64'h0000000B_0000000A), NB'(8'hFF));
        run_op(1'b0, 2'b10, 1'b1, NW'(2), 32'h100, 32'hFFFFFFFC, '0, '0);
`else
        // Byte gather, nelem 0 selects CAP
        fill_rd(32'h44332211);
        repeat (4) push_txn(32'h1000, 1'b0, 4'h0, 32'h0);
        push_done(6, 1'b0, 1'b0, DW'(32'h44332211), NB'(4'hF));
        run_op(1'b0, 2'b00, 1'b0, NW'(0), 32'h1000, 32'h0, DW'(32'h03020100), '0);

        // Halfword scatter at odd halfword offsets
        push_txn(32'h2000, 1'b1, 4'b1100, 32'hCAFE0000);
        push_txn(32'h2004, 1'b1, 4'b1100, 32'hBEEF0000);
        push_done(4, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 2'b01, 1'b0, NW'(2), 32'h2000, 32'h0, DW'(32'h00060002), DW'(32'hBEEFCAFE));

        // Halfword gather with misaligned element 1
        push_done(2, 1'b1, 1'b0, '0, '0);
        run_op(1'b0, 2'b01, 1'b0, NW'(2), 32'h3000, 32'h0, DW'(32'h00030000), '0);

        // Same index but nelem 1: misaligned lane is inactive
        rd_tab[0] = 32'h55667788;
        push_txn(32'h3000, 1'b0, 4'h0, 32'h0);
        push_done(3, 1'b0, 1'b0, DW'(32'h00007788), NB'(4'h3));
        run_op(1'b0, 2'b01, 1'b0, NW'(1), 32'h3000, 32'h0, DW'(32'h00030000), '0);

        // Halfword gather, nelem above CAP clamps to 2
        rd_tab[0] = 32'h55667788; rd_tab[1] = 32'h11223344;
        push_txn(32'h3000, 1'b0, 4'h0, 32'h0);
        push_txn(32'h3000, 1'b0, 4'h0, 32'h0);
        push_done(4, 1'b0, 1'b0, DW'(32'h11227788), NB'(4'hF));
        run_op(1'b0, 2'b01, 1'b0, NW'(7), 32'h3000, 32'h0, DW'(32'h00020000), '0);

        // Byte gather with 3 stall cycles on element 1
        fill_rd(32'h44332211);
        stall_elem = 1; stall_left = 3;
        repeat (4) push_txn(32'h1000, 1'b0, 4'h0, 32'h0);
        push_done(9, 1'b0, 1'b0, DW'(32'h44332211), NB'(4'hF));
        run_op(1'b0, 2'b00, 1'b0, NW'(4), 32'h1000, 32'h0, DW'(32'h03020100), '0);

        // Byte gather with bus error on element 2
        err_elem = 2;
        repeat (3) push_txn(32'h1000, 1'b0, 4'h0, 32'h0);
        push_done(5, 1'b0, 1'b1, '0, '0);
        run_op(1'b0, 2'b00, 1'b0, NW'(4), 32'h1000, 32'h0, DW'(32'h03020100), '0);

        // Reserved element size
        push_done(2, 1'b1, 1'b0, '0, '0);
        run_op(1'b0, 2'b11, 1'b0, NW'(1), 32'h4000, 32'h0, '0, '0);
`endif

        // Word scatter, single element
        push_txn(32'h4008, 1'b1, 4'hF, 32'h12345678);
        push_done(3, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 2'b10, 1'b0, NW'(1), 32'h4000, 32'h0, DW'(32'h8), DW'(32'h12345678));

        // Reset asserted mid-ACCESS drops cen at once
        mon_en = 1'b0;
        acc_idx = 0;
        fill_rd(32'h44332211);
        @(posedge g_clk); #1;
        sg_is_store = 1'b0; sg_esize = 2'b00; sg_mode = 1'b0; sg_nelem = NW'(4);
        sg_base = 32'h1000; sg_index = DW'(32'h03020100);
        sg_ivalid = 1'b1;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge g_clk);
            if (cop_mem_cen) seen = 1;
        end
        chk("rst_pre_cen", 128'(cop_mem_cen), 128'(1));
        #1;
        g_resetn = 1'b0;
        #1;
        chk("rst_mid_cen",  128'(cop_mem_cen),  128'(0));
        chk("rst_mid_addr", 128'(cop_mem_addr), 128'(0));
        sg_ivalid = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        mon_en = 1'b1;

        // Recovery after reset
        push_txn(32'h4008, 1'b1, 4'hF, 32'h12345678);
        push_done(3, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 2'b10, 1'b0, NW'(1), 32'h4000, 32'h0, DW'(32'h8), DW'(32'h12345678));

        repeat (2) @(posedge g_clk);
        chk("done_left", 128'(exp_done.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_cop_sgmem.md
# scarv_cop_sgmem

Parametrised scatter/gather memory engine for the SCARV coprocessor, sitting beside the single-access load/store unit on the shared coprocessor memory bus. It moves up to DATA_W/8 byte, halfword or word elements between one packed CPR value and independently addressed memory locations, one 32-bit bus transaction per element. Gathered data is written back atomically, only on full success. Optional strided addressing is also supported.

## Interface
- DATA_W, 32, packed CPR width; 32 or 64. Derived CAP = DATA_W/(8·esize_bytes) elements.
- g_clk  in  1  global clock
- g_resetn  in  1  reset; asynchronous, active-low
- sg_ivalid  in  1  instruction valid; all sg_* inputs stable while high
- sg_idone  out  1  one-cycle completion pulse
- sg_is_store  in  1  1 = scatter, 0 = gather
- sg_esize  in  2  00 byte, 01 halfword, 10 word; 11 is an address error
- sg_mode  in  1  0 indexed, 1 strided (SCARV_COP_SG_STRIDE_EN only)
- sg_nelem  in  $clog2(DATA_W/8)+1  element count; 0 or >CAP means CAP
- sg_base  in  32  base address (GPR rs1)
- sg_stride  in  32  byte stride (GPR rs2), two's complement
- sg_index  in  DATA_W  packed unsigned offsets, lane i of width esize
- sg_sdata  in  DATA_W  packed store data, lane i of width esize
- sg_rd_wdata  out  DATA_W  gathered data
- sg_rd_ben  out  DATA_W/8  writeback byte enables
- sg_addr_error  out  1  misalignment, valid with sg_idone
- sg_bus_error  out  1  bus error, valid with sg_idone
- cop_mem_cen, cop_mem_wen  out  1  chip / write enable
- cop_mem_addr  out  32  word-aligned address
- cop_mem_wdata  out  32  write data
- cop_mem_ben  out  4  write byte enables
- cop_mem_rdata  in  32  read data
- cop_mem_stall  in  1  hold request
- cop_mem_error  in  1  bus error

## Operation
- Element address:
  - indexed: A_i = sg_base + zext(sg_index lane i)
  - strided: A_i = sg_base + i·sg_stride
  - arithmetic is modulo 2^32
- Misaligned: halfword with A_i[0]=1; word with A_i[1:0]≠0. Any misaligned i < nelem, or esize=11, gives an addr_error; no bus traffic is issued.
- FSM states: IDLE, CHECK, ACCESS, DONE.
  - IDLE: on sg_ivalid, latch mode, clear the gather buffer and cnt, go to CHECK.
  - CHECK: on any address error, go to DONE with aerr=1; otherwise go to ACCESS.
  - ACCESS: drive element cnt. On acceptance (cen & !stall):
    - if cop_mem_error: set berr=1, go to DONE;
    - else on a load, merge the byte-lane-extracted rdata (lane selected by A_cnt[1:0]) into buffer lane cnt;
    - if cnt = nelem−1, go to DONE; else cnt+1.
  - DONE: sg_idone=1, then go to IDLE.
- Bus drive (registered):
  - cop_mem_addr = A_cnt & ~3.
  - wen = sg_is_store.
  - Store: ben covers esize bytes at A_cnt[1:0]; wdata = lane cnt shifted by 8·A_cnt[1:0]; unused bits 0.
  - Load: ben = 0.
- Writeback, in DONE only:
  - good gather: sg_rd_wdata = buffer; sg_rd_ben = bytes of lanes 0..nelem−1.
  - scatter or any error: sg_rd_ben = 0, sg_rd_wdata = 0.
- Errors: addr_error and bus_error are mutually exclusive and driven only with sg_idone; no partial writeback on error.

## Timing
- Reset (asynchronous, immediate) values:
  - FSM in IDLE, cnt = 0, buffer = 0.
  - All outputs 0: sg_idone, both error flags, sg_rd_*, cop_mem_cen/wen/addr/wdata/ben.
- Reset mid-ACCESS drops cen in the same cycle; the instruction is lost.
- Bus: a transaction completes in the cycle where cen=1 and stall=0. rdata and error are sampled that cycle. While stall=1, cen/addr/wdata/ben are held unchanged.
- Zero-stall latency: ivalid sampled at cycle 0, CHECK at cycle 1, elements issued at cycles 2..nelem+1, sg_idone at cycle nelem+2.
- Address error: sg_idone at cycle 2.
- Each stall cycle adds one cycle of latency.
- The cycle after sg_idone is IDLE. sg_ivalid high there is a new instruction, so the requester drops ivalid combinationally on sg_idone.
- sg_ivalid falling before sg_idone is illegal. Behaviour is undefined, except that the block returns to IDLE within nelem+2 cycles of the last stall.

## Configuration
- SCARV_COP_SG_STRIDE_EN defined: sg_mode=1 selects strided addressing.
- SCARV_COP_SG_STRIDE_EN undefined: sg_mode and sg_stride are ignored, the stride multiplier is not built, and addressing is always indexed.

## Test plan
- Byte gather, DATA_W=32: base=0x1000, index=0x03020100, rdata always 0x44332211, no stall.
  - Expect bus addr 0x1000 at cycles 2–5.
  - Expect sg_idone at cycle 6, sg_rd_wdata=0x44332211, sg_rd_ben=0xF.
- Halfword scatter: base=0x2000, index=0x00060002, sdata=0xBEEFCAFE.
  - Expect txn 1: addr 0x2000, ben 1100, wdata 0xCAFE0000.
  - Expect txn 2: addr 0x2004, ben 1100, wdata 0xBEEF0000.
  - Expect sg_rd_ben=0.
- Halfword gather with index=0x00030000: expect sg_idone and sg_addr_error at cycle 2, cen never asserted, sg_rd_ben=0.
- Byte gather with stall held high for 3 cycles on element 1: expect cen/addr held stable throughout, sg_idone at cycle 9.
- Byte gather with cop_mem_error on element 2:
  - Expect sg_idone and sg_bus_error.
  - Expect element 3 never issued and sg_rd_ben=0.
- Strided mode (macro on), DATA_W=64, word gather, base=0x100, stride=0xFFFFFFFC, nelem=2, rdata 0xA then 0xB.
  - Expect addrs 0x100 then 0x0FC.
  - Expect sg_rd_wdata=0x0000000B_0000000A, sg_rd_ben=0xFF.
  - Then drive g_resetn low mid-ACCESS: expect cen=0 immediately.
